cmp_share_arb: RTL and testbench
================================

Name: cmp_share_arb

Overview:
- Shares the pipeline's single 32-bit magnitude/equality comparator between two requesters: the branch resolver (port 0: BEQ/BNE/BLT/BGE/BLTU/BGEU) and the ALU set-less-than path (port 1: SLT/SLTI/SLTU/SLTIU).
- Arbitrates round-robin, drives the comparator operands and the signed/unsigned select, and decodes the comparator's less/equal outputs per requester.
- Registers each result into a one-entry per-port response buffer with a valid/ready handshake.
- Sits in EX between the operand-forwarding muxes and the branch/writeback logic.

Parameters:
- XLEN, 32, operand width.
- RR_INIT, 0, round-robin pointer value after reset (0 or 1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- br_valid_i  in  1  branch request valid.
- br_ready_o  out  1  branch request accepted this cycle.
- br_funct3_i  in  3  branch funct3.
- br_a_i  in  XLEN  rs1 value.
- br_b_i  in  XLEN  rs2 value.
- br_flush_i  in  1  kill any pending branch request and branch response.
- br_rsp_valid_o  out  1  branch response valid.
- br_rsp_ready_i  in  1  branch consumer ready.
- br_taken_o  out  1  branch condition result.
- slt_valid_i  in  1  SLT request valid.
- slt_ready_o  out  1  SLT request accepted this cycle.
- slt_uns_i  in  1  1 = SLTU/SLTIU.
- slt_a_i  in  XLEN  operand a.
- slt_b_i  in  XLEN  operand b.
- slt_rsp_valid_o  out  1  SLT response valid.
- slt_rsp_ready_i  in  1  SLT consumer ready.
- slt_result_o  out  XLEN  zero-extended SLT result (0 or 1).
- cmp_a_o  out  XLEN  comparator operand a.
- cmp_b_o  out  XLEN  comparator operand b.
- cmp_uns_o  out  1  comparator unsigned select.
- cmp_lt_i  in  1  comparator a<b result, combinational.
- cmp_eq_i  in  1  comparator a==b result, combinational.

Behaviour:
- Reset: clk_i and rst_i are the only clock and reset; reset is synchronous and active-high. All response valids, br_taken_o and slt_result_o = 0; round-robin pointer rr = RR_INIT. Reset mid-transaction drops everything; no response is emitted for an accepted-but-undelivered request.
- Eligibility: port p is eligible when req_valid=1 and its response buffer is empty, or full and drained this cycle (rsp_valid & rsp_ready).
- Branch-side qualifier: port 0 is additionally ineligible when br_flush_i=1.
- Grant: one grant per cycle. If only one port is eligible, it wins. If both are eligible, the port named by rr wins, then rr <= ~winner. rr is unchanged when there is no contention.
- Ready: ready_o is asserted only for the granted port, combinationally in the same cycle. Requesters hold valid and operands stable until ready.
- Comparator drive: cmp_a_o/cmp_b_o/cmp_uns_o = granted port's operands. With no grant, they hold the last granted values (no toggling).
  - cmp_uns_o = br_funct3_i[1] for port 0.
  - cmp_uns_o = slt_uns_i for port 1.
- Branch decode, captured at grant:
  - funct3 000: taken = eq.
  - funct3 001: taken = ~eq.
  - funct3 100 and 110: taken = lt.
  - funct3 101 and 111: taken = ~lt.
  - funct3 010 and 011 (illegal): taken = 0, and a response is still produced.
- SLT decode: result = {XLEN-1 zeros, lt}.
- Latency: a request accepted in cycle N gives rsp_valid=1 from cycle N+1. The response holds until rsp_ready=1.
- Throughput: each port accepts one request per cycle back-to-back if its consumer is always ready. Total throughput is limited to 1 comparison per cycle.
- Simultaneous drain and grant on the same port: the buffer reloads with the new result and rsp_valid stays 1.
- br_flush_i=1: clears the branch response buffer that cycle; this overrides a pending handshake. It blocks a branch grant. It does not affect the SLT port or rr.
- Outputs are not X when idle. Response data holds its last value while valid=0.

Optional Feature:
- Macro CMP_ARB_STATS_EN.
- When defined, adds three outputs, stat_br_grants_o (32), stat_slt_grants_o (32) and stat_conflict_o (32):
  - stat_br_grants_o and stat_slt_grants_o count accepted requests per port.
  - stat_conflict_o counts cycles where both ports were eligible.
  - All three are saturating, reset to 0 and not cleared by flush.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Branch alone: BLT, a=0xFFFF_FFFF, b=0x0000_0001, comparator model signed -> cmp_uns_o=0; next cycle br_rsp_valid_o=1, br_taken_o=1. Same operands with BLTU -> cmp_uns_o=1, taken=0.
- SLT alone: SLTU, a=5, b=5 -> slt_result_o=0x0000_0000 at N+1. SLT, a=0x8000_0000, b=0 -> 0x0000_0001.
- Contention: both valid for 4 cycles, consumers always ready, RR_INIT=0 -> grants alternate 0,1,0,1; each port receives 2 responses in order; stat_conflict_o=4 when CMP_ARB_STATS_EN is defined.
- Backpressure: slt_rsp_ready_i=0 with the SLT buffer full and a second SLT request pending -> slt_ready_o=0 and branch requests continue to be granted. Raise ready -> drain and accept in the same cycle, slt_rsp_valid_o stays 1.
- Flush: branch accepted in cycle N, br_flush_i=1 in cycle N+1 with br_rsp_ready_i=0 -> br_rsp_valid_o=0 at N+2. A branch request presented with flush=1 gets no ready.
- Reset mid-op: assert rst_i with both response buffers full -> all valids 0 next cycle, rr=RR_INIT, and no stale response after reset release.

Source files
------------

// File: rtl/cmp_share_arb_if.sv
// Request, response and comparator signals of the shared-comparator arbiter.
// The slave modport is the arbiter; master is the requesters, consumers and comparator.
interface cmp_share_arb_if #(parameter int XLEN = 32);
  logic            br_valid_i;
  logic            br_ready_o;
  logic [2:0]      br_funct3_i;
  logic [XLEN-1:0] br_a_i;
  logic [XLEN-1:0] br_b_i;
  logic            br_flush_i;
  logic            br_rsp_valid_o;
  logic            br_rsp_ready_i;
  logic            br_taken_o;

  logic            slt_valid_i;
  logic            slt_ready_o;
  logic            slt_uns_i;
  logic [XLEN-1:0] slt_a_i;
  logic [XLEN-1:0] slt_b_i;
  logic            slt_rsp_valid_o;
  logic            slt_rsp_ready_i;
  logic [XLEN-1:0] slt_result_o;

  logic [XLEN-1:0] cmp_a_o;
  logic [XLEN-1:0] cmp_b_o;
  logic            cmp_uns_o;
  logic            cmp_lt_i;
  logic            cmp_eq_i;

  modport slave (
    input  br_valid_i, br_funct3_i, br_a_i, br_b_i, br_flush_i, br_rsp_ready_i,
    output br_ready_o, br_rsp_valid_o, br_taken_o,
    input  slt_valid_i, slt_uns_i, slt_a_i, slt_b_i, slt_rsp_ready_i,
    output slt_ready_o, slt_rsp_valid_o, slt_result_o,
    output cmp_a_o, cmp_b_o, cmp_uns_o,
    input  cmp_lt_i, cmp_eq_i
  );

  modport master (
    output br_valid_i, br_funct3_i, br_a_i, br_b_i, br_flush_i, br_rsp_ready_i,
    input  br_ready_o, br_rsp_valid_o, br_taken_o,
    output slt_valid_i, slt_uns_i, slt_a_i, slt_b_i, slt_rsp_ready_i,
    input  slt_ready_o, slt_rsp_valid_o, slt_result_o,
    input  cmp_a_o, cmp_b_o, cmp_uns_o,
    output cmp_lt_i, cmp_eq_i
  );
endinterface

// File: rtl/cmp_share_arb.sv
// Round-robin sharing of one magnitude/equality comparator between branch and SLT paths,
// with a one-entry response buffer per port. Define CMP_ARB_STATS_EN for grant/conflict counters.
module cmp_share_arb #(
  parameter int XLEN    = 32,
  parameter bit RR_INIT = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  cmp_share_arb_if.slave        bus
`ifdef CMP_ARB_STATS_EN
  ,
  output logic [31:0]           stat_br_grants_o,
  output logic [31:0]           stat_slt_grants_o,
  output logic [31:0]           stat_conflict_o
`endif
);
  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            uns;
  } cmp_req_t;

  logic     rr;
  cmp_req_t held_q, sel;
  logic     br_elig, slt_elig, gnt_br, gnt_slt, conflict;
  logic     br_rsp_v_q, br_taken_q, slt_rsp_v_q, slt_lt_q;

  function automatic logic br_decode(input logic [2:0] f3, input logic lt, input logic eq);
    case (f3)
      3'b000:        return eq;
      3'b001:        return ~eq;
      3'b100, 3'b110: return lt;
      3'b101, 3'b111: return ~lt;
      default:       return 1'b0;
    endcase
  endfunction

  // A full buffer still counts as free when its consumer drains it this cycle.
  assign br_elig  = bus.br_valid_i & ~bus.br_flush_i & (~br_rsp_v_q | bus.br_rsp_ready_i);
  assign slt_elig = bus.slt_valid_i & (~slt_rsp_v_q | bus.slt_rsp_ready_i);
  assign conflict = br_elig & slt_elig;
  assign gnt_br   = br_elig & (~slt_elig | ~rr);
  assign gnt_slt  = slt_elig & (~br_elig | rr);

  assign bus.br_ready_o  = gnt_br;
  assign bus.slt_ready_o = gnt_slt;

  // Operands hold the last grant when idle so the comparator does not toggle.
  always_comb begin
    sel = held_q;
    if (gnt_br)       sel = {bus.br_a_i, bus.br_b_i, bus.br_funct3_i[1]};
    else if (gnt_slt) sel = {bus.slt_a_i, bus.slt_b_i, bus.slt_uns_i};
  end

  assign bus.cmp_a_o   = sel.a;
  assign bus.cmp_b_o   = sel.b;
  assign bus.cmp_uns_o = sel.uns;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr          <= RR_INIT;
      held_q      <= '0;
      br_rsp_v_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      slt_rsp_v_q <= 1'b0;
      slt_lt_q    <= 1'b0;
    end else begin
      held_q <= sel;
      // Contention winner hands priority to the other port.
      if (conflict) rr <= gnt_br;

      if (bus.br_flush_i) begin
        br_rsp_v_q <= 1'b0;
      end else if (gnt_br) begin
        br_rsp_v_q <= 1'b1;
        br_taken_q <= br_decode(bus.br_funct3_i, bus.cmp_lt_i, bus.cmp_eq_i);
      end else if (bus.br_rsp_ready_i) begin
        br_rsp_v_q <= 1'b0;
      end

      if (gnt_slt) begin
        slt_rsp_v_q <= 1'b1;
        slt_lt_q    <= bus.cmp_lt_i;
      end else if (bus.slt_rsp_ready_i) begin
        slt_rsp_v_q <= 1'b0;
      end
    end
  end

  assign bus.br_rsp_valid_o  = br_rsp_v_q;
  assign bus.br_taken_o      = br_taken_q;
  assign bus.slt_rsp_valid_o = slt_rsp_v_q;
  assign bus.slt_result_o    = {{(XLEN-1){1'b0}}, slt_lt_q};

`ifdef CMP_ARB_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_br_grants_o  <= '0;
      stat_slt_grants_o <= '0;
      stat_conflict_o   <= '0;
    end else begin
      if (gnt_br   && stat_br_grants_o  != '1) stat_br_grants_o  <= stat_br_grants_o + 32'd1;
      if (gnt_slt  && stat_slt_grants_o != '1) stat_slt_grants_o <= stat_slt_grants_o + 32'd1;
      if (conflict && stat_conflict_o   != '1) stat_conflict_o   <= stat_conflict_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cmp_share_arb.sv
// Directed vector bench for cmp_share_arb, with a behavioural comparator on the cmp_* ports.
module tb_cmp_share_arb;
  localparam int XLEN = 32;
  localparam int NV   = 27;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  cmp_share_arb_if #(.XLEN(XLEN)) bus();

`ifdef CMP_ARB_STATS_EN
  logic [31:0] stat_br_grants_o, stat_slt_grants_o, stat_conflict_o;
`endif

  cmp_share_arb #(.XLEN(XLEN), .RR_INIT(1'b0)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
`ifdef CMP_ARB_STATS_EN
    ,
    .stat_br_grants_o  (stat_br_grants_o),
    .stat_slt_grants_o (stat_slt_grants_o),
    .stat_conflict_o   (stat_conflict_o)
`endif
  );

  assign bus.cmp_lt_i = bus.cmp_uns_o ? (bus.cmp_a_o < bus.cmp_b_o)
                                      : ($signed(bus.cmp_a_o) < $signed(bus.cmp_b_o));
  assign bus.cmp_eq_i = (bus.cmp_a_o == bus.cmp_b_o);

  typedef struct {
    logic        bv;  logic [2:0] f3; logic [31:0] ba; logic [31:0] bb; logic fl; logic brr;
    logic        sv;  logic su;       logic [31:0] sa; logic [31:0] sb; logic srr;
    logic        ebr; logic esr;      logic eu;
    logic        erv; logic etk;      logic esv;       logic [31:0] eres;
  } vec_t;

  vec_t vecs[NV];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(
    input logic bv, input logic [2:0] f3, input logic [31:0] ba, input logic [31:0] bb,
    input logic fl, input logic brr,
    input logic sv, input logic su, input logic [31:0] sa, input logic [31:0] sb, input logic srr,
    input logic ebr, input logic esr, input logic eu,
    input logic erv, input logic etk, input logic esv, input logic [31:0] eres);
    vec_t v;
    v.bv = bv; v.f3 = f3; v.ba = ba; v.bb = bb; v.fl = fl; v.brr = brr;
    v.sv = sv; v.su = su; v.sa = sa; v.sb = sb; v.srr = srr;
    v.ebr = ebr; v.esr = esr; v.eu = eu;
    v.erv = erv; v.etk = etk; v.esv = esv; v.eres = eres;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    bus.br_valid_i      = v.bv;  bus.br_funct3_i = v.f3; bus.br_a_i = v.ba; bus.br_b_i = v.bb;
    bus.br_flush_i      = v.fl;  bus.br_rsp_ready_i = v.brr;
    bus.slt_valid_i     = v.sv;  bus.slt_uns_i = v.su;   bus.slt_a_i = v.sa; bus.slt_b_i = v.sb;
    bus.slt_rsp_ready_i = v.srr;
  endtask

  task automatic idle();
    apply(mk(0, 3'b000, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    // bv f3 ba bb fl brr | sv su sa sb srr | ebr esr eu | erv etk esv eres
    vecs[0]  = mk(1, 3'b100, 32'hFFFF_FFFF, 1, 0, 1,  0, 0, 0, 0, 1,  1, 0, 0,  1, 1, 0, 0);
    vecs[1]  = mk(1, 3'b110, 32'hFFFF_FFFF, 1, 0, 1,  0, 0, 0, 0, 1,  1, 0, 1,  1, 0, 0, 0);
    vecs[2]  = mk(0, 3'b000, 0, 0, 0, 1,              0, 0, 0, 0, 1,  0, 0, 0,  0, 0, 0, 0);
    vecs[3]  = mk(0, 3'b000, 0, 0, 0, 1,              1, 1, 5, 5, 1,  0, 1, 1,  0, 0, 1, 0);
    vecs[4]  = mk(0, 3'b000, 0, 0, 0, 1,  1, 0, 32'h8000_0000, 0, 1,  0, 1, 0,  0, 0, 1, 1);
    vecs[5]  = mk(1, 3'b000, 3, 3, 0, 1,              0, 0, 0, 0, 1,  1, 0, 0,  1, 1, 0, 1);
    vecs[6]  = mk(1, 3'b001, 3, 3, 0, 1,              0, 0, 0, 0, 1,  1, 0, 0,  1, 0, 0, 1);
    vecs[7]  = mk(1, 3'b101, 32'hFFFF_FFFF, 1, 0, 1,  0, 0, 0, 0, 1,  1, 0, 0,  1, 0, 0, 1);
    vecs[8]  = mk(1, 3'b111, 32'hFFFF_FFFF, 1, 0, 1,  0, 0, 0, 0, 1,  1, 0, 1,  1, 1, 0, 1);
    vecs[9]  = mk(1, 3'b010, 0, 1, 0, 1,              0, 0, 0, 0, 1,  1, 0, 1,  1, 0, 0, 1);
    vecs[10] = mk(1, 3'b110, 0, 1, 0, 1,              0, 0, 0, 0, 1,  1, 0, 1,  1, 1, 0, 1);
    // four cycles of contention: grants 0,1,0,1
    vecs[11] = mk(1, 3'b000, 7, 7, 0, 1,              1, 0, 2, 9, 1,  1, 0, 0,  1, 1, 0, 1);
    vecs[12] = mk(1, 3'b001, 7, 7, 0, 1,              1, 0, 2, 9, 1,  0, 1, 0,  0, 1, 1, 1);
    vecs[13] = mk(1, 3'b001, 7, 7, 0, 1,              1, 1, 9, 2, 1,  1, 0, 0,  1, 0, 0, 1);
    vecs[14] = mk(1, 3'b100, 1, 2, 0, 1,              1, 1, 9, 2, 1,  0, 1, 1,  0, 0, 1, 0);
    vecs[15] = mk(1, 3'b100, 1, 2, 0, 1,              1, 0, 1, 2, 1,  1, 0, 0,  1, 1, 0, 0);
    // SLT backpressure while branches keep flowing
    vecs[16] = mk(0, 3'b000, 0, 0, 0, 1,              1, 0, 1, 2, 0,  0, 1, 0,  0, 1, 1, 1);
    vecs[17] = mk(1, 3'b000, 4, 4, 0, 1,              1, 1, 3, 2, 0,  1, 0, 0,  1, 1, 1, 1);
    vecs[18] = mk(1, 3'b100, 5, 4, 0, 1,              1, 1, 3, 2, 0,  1, 0, 0,  1, 0, 1, 1);
    vecs[19] = mk(0, 3'b000, 0, 0, 0, 1,              1, 1, 3, 2, 1,  0, 1, 1,  0, 0, 1, 0);
    // flush kills the held branch response and blocks a branch grant
    vecs[20] = mk(1, 3'b000, 1, 1, 0, 0,              0, 0, 0, 0, 1,  1, 0, 0,  1, 1, 0, 0);
    vecs[21] = mk(1, 3'b001, 1, 2, 1, 0,              1, 0, 0, 1, 1,  0, 1, 0,  0, 1, 1, 1);
    vecs[22] = mk(1, 3'b001, 1, 2, 0, 1,              0, 0, 0, 0, 1,  1, 0, 0,  1, 1, 0, 1);
    vecs[23] = mk(1, 3'b000, 0, 0, 0, 1,              1, 0, 5, 1, 1,  0, 1, 0,  0, 1, 1, 0);
    vecs[24] = mk(1, 3'b000, 0, 0, 0, 1,              0, 0, 0, 0, 1,  1, 0, 0,  1, 1, 0, 0);
    vecs[25] = mk(1, 3'b101, 2, 1, 0, 1,              1, 1, 1, 2, 1,  1, 0, 0,  1, 1, 0, 0);
    vecs[26] = mk(0, 3'b000, 0, 0, 0, 1,              1, 1, 1, 2, 1,  0, 1, 1,  0, 1, 1, 1);

    idle();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_br_rsp_valid",  0, bus.br_rsp_valid_o,  0);
    chk("rst_br_taken",      0, bus.br_taken_o,      0);
    chk("rst_slt_rsp_valid", 0, bus.slt_rsp_valid_o, 0);
    chk("rst_slt_result",    0, bus.slt_result_o,    0);
    chk("rst_cmp_known",     0, 32'($isunknown({bus.cmp_a_o, bus.cmp_b_o, bus.cmp_uns_o})), 0);
    rst_i = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk_i);
      apply(vecs[i]);
      #1;
      chk("br_ready",  i, bus.br_ready_o,  vecs[i].ebr);
      chk("slt_ready", i, bus.slt_ready_o, vecs[i].esr);
      if (vecs[i].ebr || vecs[i].esr) chk("cmp_uns", i, bus.cmp_uns_o, vecs[i].eu);
      @(posedge clk_i);
      #1;
      chk("br_rsp_valid",  i, bus.br_rsp_valid_o,  vecs[i].erv);
      chk("br_taken",      i, bus.br_taken_o,      vecs[i].etk);
      chk("slt_rsp_valid", i, bus.slt_rsp_valid_o, vecs[i].esv);
      chk("slt_result",    i, bus.slt_result_o,    vecs[i].eres);
`ifdef CMP_ARB_STATS_EN
      if (i == 14) chk("stat_conflict_4", i, stat_conflict_o, 4);
`endif
    end

`ifdef CMP_ARB_STATS_EN
    chk("stat_br_grants",  NV, stat_br_grants_o,  17);
    chk("stat_slt_grants", NV, stat_slt_grants_o, 9);
    chk("stat_conflict",   NV, stat_conflict_o,   7);
`endif

    // Fill both buffers (SLT already holds a response), then reset mid-transaction.
    @(negedge clk_i);
    apply(mk(1, 3'b000, 6, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk_i); #1;
    chk("full_br_rsp_valid",  100, bus.br_rsp_valid_o,  1);
    chk("full_slt_rsp_valid", 100, bus.slt_rsp_valid_o, 1);
    @(negedge clk_i);
    bus.br_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    chk("midrst_br_rsp_valid",  101, bus.br_rsp_valid_o,  0);
    chk("midrst_slt_rsp_valid", 101, bus.slt_rsp_valid_o, 0);
    chk("midrst_br_taken",      101, bus.br_taken_o,      0);
    chk("midrst_slt_result",    101, bus.slt_result_o,    0);
`ifdef CMP_ARB_STATS_EN
    chk("midrst_stat_br", 101, stat_br_grants_o, 0);
    chk("midrst_stat_cf", 101, stat_conflict_o,  0);
`endif
    @(negedge clk_i);
    rst_i = 1'b0;
    idle();
    @(posedge clk_i); #1;
    chk("post_br_rsp_valid",  102, bus.br_rsp_valid_o,  0);
    chk("post_slt_rsp_valid", 102, bus.slt_rsp_valid_o, 0);
    // rr was 1 before reset; RR_INIT=0 must give the branch port priority again.
    @(negedge clk_i);
    apply(mk(1, 3'b000, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("rr_init_br_ready",  103, bus.br_ready_o,  1);
    chk("rr_init_slt_ready", 103, bus.slt_ready_o, 0);
    @(negedge clk_i);
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
